// File: rtl/reg_bank_scanner_if.sv
// Command, bank read-port and output-stream signals of the register bank scanner.
// The master modport is the scanner's view; the slave modport is the bank/consumer side.
interface reg_bank_scanner_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic                     start;
   logic [ADDR_W-1:0]        first_addr;
   logic [ADDR_W-1:0]        last_addr;
   logic [ADDR_W-1:0]        addrB;
   logic [DATA_W-1:0]        rd_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [ADDR_W-1:0]        out_addr;
   logic [DATA_W-1:0]        out_data;
   logic                     busy;
   logic                     done;
   logic [ADDR_W+DATA_W-1:0] checksum;

   modport master (
      input  start, first_addr, last_addr, rd_data, out_ready,
      output addrB, out_valid, out_addr, out_data, busy, done, checksum
   );

   modport slave (
      output start, first_addr, last_addr, rd_data, out_ready,
      input  addrB, out_valid, out_addr, out_data, busy, done, checksum
   );
endinterface

// File: rtl/reg_bank_scanner.sv
// Sweeps the bank read address over [first_addr..last_addr] (wrapping), captures each byte
// and streams {addr,data} beats out through a credit-protected FIFO with a running checksum.
module reg_bank_scanner #(
   parameter int ADDR_W     = 4,
   parameter int DATA_W     = 8,
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 CLKB,
   input  logic                 RSTB_n,
   reg_bank_scanner_if.master   bus
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LAT + 1);
   localparam int SUM_W = ADDR_W + DATA_W;

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   state_t              state;
   state_t              state_nxt;

   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W-1:0]   next_addr;
   logic [ADDR_W-1:0]   last_q;

   logic                tag_vld_p  [RD_LAT];
   logic [ADDR_W-1:0]   tag_addr_p [RD_LAT];

   logic [ADDR_W-1:0]   fifo_addr [FIFO_DEPTH];
   logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [CNT_W-1:0]    occ;
   logic [CNT_W-1:0]    inflight;

   logic [SUM_W-1:0]    csum;

   logic                accept_start;
   logic                credit_ok;
   logic                issue;
   logic                last_issue;
   logic                fifo_wr;
   logic                fifo_rd;
   logic                head_vld;

   function automatic logic [SUM_W-1:0] csum_add(input logic [SUM_W-1:0] acc,
                                                 input logic [DATA_W-1:0] d);
      return acc + SUM_W'(d);
   endfunction

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + CNT_W'(tag_vld_p[i]);
      end
   end

   // Counting in-flight reads against FIFO space means a read is only issued when its
   // landing slot is already reserved, whatever the consumer does with out_ready.
   assign head_vld     = (occ != '0);
   assign accept_start = (state == IDLE) && bus.start;
   assign credit_ok    = (inflight + occ) < CNT_W'(FIFO_DEPTH);
   assign issue        = (state == SCAN) && credit_ok;
   assign last_issue   = issue && (next_addr == last_q);
   assign fifo_wr      = tag_vld_p[RD_LAT-1];
   assign fifo_rd      = head_vld && bus.out_ready;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (bus.start) state_nxt = SCAN;
         SCAN:  if (last_issue) state_nxt = DRAIN;
         DRAIN: if ((inflight == '0) && (occ == CNT_W'(1)) && fifo_rd) state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLKB or negedge RSTB_n) begin
      if (!RSTB_n) begin
         state     <= IDLE;
         addr_q    <= '0;
         next_addr <= '0;
         last_q    <= '0;
      end else begin
         state <= state_nxt;
         if (accept_start) begin
            next_addr <= bus.first_addr;
            last_q    <= bus.last_addr;
         end else if (issue) begin
            addr_q    <= next_addr;
            next_addr <= next_addr + ADDR_W'(1);
         end
      end
   end

   // ---- read-latency tag pipe: valid is control, address rides along unreset ----
   always_ff @(posedge CLKB or negedge RSTB_n) begin
      if (!RSTB_n) begin
         for (int i = 0; i < RD_LAT; i++) tag_vld_p[i] <= 1'b0;
      end else begin
         tag_vld_p[0] <= issue;
         for (int i = 1; i < RD_LAT; i++) tag_vld_p[i] <= tag_vld_p[i-1];
      end
   end

   always_ff @(posedge CLKB) begin
      tag_addr_p[0] <= next_addr;
      for (int i = 1; i < RD_LAT; i++) tag_addr_p[i] <= tag_addr_p[i-1];
   end

   // ---- capture FIFO: pointers and occupancy reset, storage does not ----
   always_ff @(posedge CLKB or negedge RSTB_n) begin
      if (!RSTB_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (fifo_wr) wr_ptr <= wr_ptr + PTR_W'(1);
         if (fifo_rd) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({fifo_wr, fifo_rd})
            2'b10:   occ <= occ + CNT_W'(1);
            2'b01:   occ <= occ - CNT_W'(1);
            default: occ <= occ;
         endcase
      end
   end

   always_ff @(posedge CLKB) begin
      if (fifo_wr) begin
         fifo_addr[wr_ptr] <= tag_addr_p[RD_LAT-1];
         fifo_data[wr_ptr] <= bus.rd_data;
      end
   end

   // ---- output stage and checksum ----
   always_ff @(posedge CLKB or negedge RSTB_n) begin
      if (!RSTB_n) begin
         csum <= '0;
      end else if (accept_start) begin
         csum <= '0;
      end else if (fifo_rd) begin
         csum <= csum_add(csum, fifo_data[rd_ptr]);
      end
   end

   // Head is masked while empty so the stream reads zero after reset, not stale storage.
   assign bus.out_valid = head_vld;
   assign bus.out_addr  = head_vld ? fifo_addr[rd_ptr] : '0;
   assign bus.out_data  = head_vld ? fifo_data[rd_ptr] : '0;
   assign bus.addrB     = addr_q;
   assign bus.busy      = (state != IDLE);
   assign bus.done      = (state == DONE);
   assign bus.checksum  = csum;

endmodule

// File: doc/reg_bank_scanner.md
Name: reg_bank_scanner

Overview:
- Read-port sequencer on the CLKB side of the 16x8 dual-clock register bank.
- On a start command it sweeps the bank's read address over a programmable range and captures each returned byte.
- Captured bytes go out as a valid/ready stream tagged with their address. A running checksum is accumulated along the way.
- Sits directly downstream of the bank's read-only port: drives its addrB and consumes its data_outB.

Parameters:
- ADDR_W, 4, bank address width (16 entries).
- DATA_W, 8, bank data width.
- RD_LAT, 2, CLKB edges from addrB register update to the edge at which rd_data holds that entry's data (1 bank register + 1 address register).
- FIFO_DEPTH, 4, output buffer entries; must be >= RD_LAT+1, power of two.

Ports:
- CLKB  in  1  scanner clock, same clock as the bank read port.
- RSTB_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle start pulse; ignored unless idle.
- first_addr  in  ADDR_W  first address of sweep, sampled on accepted start.
- last_addr  in  ADDR_W  last address of sweep, sampled on accepted start.
- addrB  out  ADDR_W  registered read address to the bank.
- rd_data  in  DATA_W  bank data_outB.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts beat.
- out_addr  out  ADDR_W  address of current beat.
- out_data  out  DATA_W  data of current beat.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when last beat has been accepted.
- checksum  out  ADDR_W+DATA_W  unsigned sum of accepted out_data since last start; no overflow at 16x255=4080.

Behaviour:
- Reset (async, RSTB_n=0): state IDLE; addrB=0; out_valid=0; out_addr=0; out_data=0; busy=0; done=0; checksum=0; FIFO empty; in-flight pipe cleared. Reset mid-sweep abandons the sweep and discards in-flight data.
- Count = ((last_addr - first_addr) mod 2^ADDR_W) + 1. If last<first the sweep wraps 15->0. first==last gives one beat. first=0, last=15 gives 16 beats.
- FSM states:
  - IDLE: on start=1, latch range, clear checksum, busy=1, go to SCAN. start while not IDLE has no effect.
  - SCAN: issue one address per cycle when credit is available. addrB updates at the issue edge, then increments mod 16.
    - Credit rule: issue only if (in-flight count + FIFO occupancy) < FIFO_DEPTH. This guarantees the FIFO never overflows under any out_ready pattern.
    - After the Count-th issue, go to DRAIN.
  - DRAIN: no issues. When in-flight count is 0, FIFO is empty, and the final beat is accepted, go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0 from the next cycle, return to IDLE. A start in the DONE cycle is ignored.
- Capture: a tag pipe of length RD_LAT carries {valid, addr} alongside each issue. rd_data is written into the FIFO with that address at the edge where the tag emerges.
- Output: FIFO head drives out_valid/out_addr/out_data.
  - Beat transfers on out_valid & out_ready. checksum += out_data on that edge.
  - out_addr/out_data hold stable while out_valid & !out_ready.
  - Beats are emitted strictly in sweep order.
- Simultaneous FIFO write and read in the same cycle is supported; occupancy is unchanged.
- Throughput: with out_ready held 1, one beat per cycle. The first out_valid appears RD_LAT+1 cycles after the accepted start edge.
- addrB holds its last issued value when not issuing.

Test Plan:
- Basic sweep: bank preloaded with mem[i]=i*3, start with first=0, last=15, out_ready=1 -> 16 beats in consecutive cycles, out_addr 0..15, out_data 0,3,...,45; checksum=360; done pulses once; busy low afterwards.
- Wrap and single entry: first=14, last=1 -> beats at addresses 14,15,0,1. first=last=5 with mem[5]=0xA5 -> exactly one beat 0xA5, checksum=0x0A5.
- Backpressure: out_ready toggles 1,0,0,1 repeating during a full sweep -> every beat delivered once in order with no loss or duplication; out_data stable while stalled; FIFO occupancy never exceeds 4; checksum matches the sum of mem.
- Start while busy: second start pulse mid-sweep with a different range -> ignored; original range completes; checksum unaffected.
- Reset mid-sweep: RSTB_n low at the 6th beat -> all outputs return to reset values immediately. A new start after release performs a fresh full sweep with correct data and checksum.
- Full-range stall: out_ready=0 for 20 cycles after start -> at most FIFO_DEPTH entries buffered and addrB issues stop. Releasing ready delivers all 16 beats in order, then done.
